sreg_parity_sequencer: RTL and testbench

//  Per-memory-cycle controller for the S-register/parity datapath. Sequences clear-S (CSG), write-S (WSG)
//  and the parity check strobe (TPARG) across the 12 timepulses of a memory cycle, and samples parity-good
//  at TP7. Counts consecutive parity failures and raises the parity alarm and a restart request.

---
 rtl/sreg_seq_pkg.sv | 38 +++
 rtl/sreg_tp_counter.sv | 28 ++
 rtl/sreg_parity_sequencer.sv | 161 ++++++++++++++++
 tb/tb_sreg_parity_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sreg_seq_pkg.sv
// Shared types and constants for the S-register/parity sequencer.
package sreg_seq_pkg;

  localparam int TPW = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  typedef enum logic [2:0] {
    EDIT_NONE = 3'd0,
    EDIT_CYR  = 3'd1,
    EDIT_SR   = 3'd2,
    EDIT_CYL  = 3'd3,
    EDIT_EDOP = 3'd4
  } edit_op_t;

  localparam int EP_CYR  = 0;
  localparam int EP_SR   = 1;
  localparam int EP_CYL  = 2;
  localparam int EP_EDOP = 3;

  // Codes 5-7 are treated as "no edit".
  function automatic logic [3:0] edit_onehot(input logic [2:0] op);
    logic [3:0] v;
    v = '0;
    case (op)
      EDIT_CYR:  v[EP_CYR]  = 1'b1;
      EDIT_SR:   v[EP_SR]   = 1'b1;
      EDIT_CYL:  v[EP_CYL]  = 1'b1;
      EDIT_EDOP: v[EP_EDOP] = 1'b1;
      default:   v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/sreg_tp_counter.sv
// Timepulse register for one memory cycle: clear, load-to-TP1, increment, last-TP flag.
module sreg_tp_counter
  import sreg_seq_pkg::*;
#(
  parameter int CYCLE_TP = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           inc,
  input  logic           clr,
  output logic [TPW-1:0] tp,
  output logic           last
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      tp <= '0;
    end else if (load) begin
      tp <= TPW'(1);
    end else if (inc) begin
      tp <= tp + 1'b1;
    end
  end

  assign last = (tp == TPW'(CYCLE_TP));

endmodule

// File: rtl/sreg_parity_sequencer.sv
// Per-memory-cycle CSG/WSG/TPARG/edit sequencer with parity fail counting and alarm.
// Optional SREG_MONPAR_EN adds the monpar input that forces the parity check to fail.
module sreg_parity_sequencer
  import sreg_seq_pkg::*;
#(
  parameter int CYCLE_TP     = 12,
  parameter int CHK_TP       = 7,
  parameter int ALARM_THRESH = 2,
  parameter int FAILW        = 3
) (
  input  logic             SIM_CLK,
  input  logic             SIM_RST,
  input  logic             start,
  input  logic             chk_en,
  input  logic [2:0]       edit_op,
  input  logic             tp_adv,
  input  logic             parity_ok,
  input  logic             gojam,
  input  logic             alarm_clr,
`ifdef SREG_MONPAR_EN
  input  logic             monpar,
`endif
  output logic             busy,
  output logic [TPW-1:0]   tp,
  output logic             csg,
  output logic             wsg,
  output logic             tparg,
  output logic [3:0]       edit_pulse,
  output logic             par_fail,
  output logic [FAILW-1:0] fail_cnt,
  output logic             alarm,
  output logic             restart_req,
  output logic             cycle_done
);

  seq_state_t       state, state_next;
  logic             tp_last;
  logic             chk_en_q;
  logic [2:0]       edit_op_q;
  logic             par_bad;

  logic             start_ok, run_adv, abort;
  logic             tp_load, tp_inc, tp_clr;
  logic [TPW-1:0]   tp_next;
  logic             chk_en_next;
  logic             chk_now, fail_now, alarm_set;
  logic [FAILW-1:0] fail_cnt_next;
  logic             alarm_next;
  logic             csg_d, wsg_d, tparg_d, cycle_done_d;
  logic [3:0]       edit_d;

`ifdef SREG_MONPAR_EN
  assign par_bad = !parity_ok || monpar;
`else
  assign par_bad = !parity_ok;
`endif

  sreg_tp_counter #(.CYCLE_TP(CYCLE_TP)) u_tp (
    .clk  (SIM_CLK),
    .rst  (SIM_RST),
    .load (tp_load),
    .inc  (tp_inc),
    .clr  (tp_clr),
    .tp   (tp),
    .last (tp_last)
  );

  assign busy = (state == RUN);

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // gojam wins over start and over the end-of-cycle edge; start may chain onto cycle_done.
  always_comb begin
    state_next    = state;
    abort         = (state == RUN) && gojam;
    run_adv       = (state == RUN) && tp_adv && !gojam;
    cycle_done_d  = run_adv && tp_last;
    start_ok      = start && !gojam && ((state == IDLE) || cycle_done_d);
    tp_load       = start_ok;
    tp_inc        = run_adv && !tp_last;
    tp_clr        = abort || (cycle_done_d && !start_ok);
    tp_next       = tp;
    chk_en_next   = start_ok ? chk_en : chk_en_q;
    chk_now       = run_adv && chk_en_q && (tp == TPW'(CHK_TP));
    fail_now      = chk_now && par_bad;
    fail_cnt_next = fail_cnt;
    alarm_set     = 1'b0;
    alarm_next    = alarm;
    csg_d         = start_ok;
    wsg_d         = tp_inc && (tp == TPW'(1));
    edit_d        = '0;
    tparg_d       = 1'b0;

    if (abort) begin
      state_next = IDLE;
      tp_next    = '0;
    end else if (start_ok) begin
      state_next = RUN;
      tp_next    = TPW'(1);
    end else if (cycle_done_d) begin
      state_next = IDLE;
      tp_next    = '0;
    end else if (tp_inc) begin
      tp_next = tp + 1'b1;
    end

    if (tp_inc && (tp == TPW'(CYCLE_TP - 1))) begin
      edit_d = edit_onehot(edit_op_q);
    end

    tparg_d = (state_next == RUN) && chk_en_next && (tp_next == TPW'(CHK_TP));

    if (fail_now) begin
      fail_cnt_next = (fail_cnt == '1) ? fail_cnt : fail_cnt + 1'b1;
    end else if (chk_now) begin
      fail_cnt_next = '0;
    end

    alarm_set = fail_now && !alarm && (fail_cnt_next >= FAILW'(ALARM_THRESH));
    if (alarm_set) begin
      alarm_next = 1'b1;
    end else if (alarm_clr) begin
      alarm_next = 1'b0;
    end
  end

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      chk_en_q    <= 1'b0;
      edit_op_q   <= '0;
      csg         <= 1'b0;
      wsg         <= 1'b0;
      tparg       <= 1'b0;
      edit_pulse  <= '0;
      par_fail    <= 1'b0;
      fail_cnt    <= '0;
      alarm       <= 1'b0;
      restart_req <= 1'b0;
      cycle_done  <= 1'b0;
    end else begin
      chk_en_q    <= chk_en_next;
      edit_op_q   <= start_ok ? edit_op : edit_op_q;
      csg         <= csg_d;
      wsg         <= wsg_d;
      tparg       <= tparg_d;
      edit_pulse  <= edit_d;
      par_fail    <= fail_now;
      fail_cnt    <= fail_cnt_next;
      alarm       <= alarm_next;
      restart_req <= alarm_set;
      cycle_done  <= cycle_done_d;
    end
  end

endmodule

// File: tb/tb_sreg_parity_sequencer.sv
// Scoreboard bench for sreg_parity_sequencer: pulse events queued by stimulus, popped by a monitor.
module tb_sreg_parity_sequencer;
  import sreg_seq_pkg::*;

  logic       SIM_CLK = 1'b0;
  logic       SIM_RST;
  logic       start, chk_en, tp_adv, parity_ok, gojam, alarm_clr;
  logic [2:0] edit_op;
`ifdef SREG_MONPAR_EN
  logic       monpar;
`endif
  logic       busy, csg, wsg, tparg, par_fail, alarm, restart_req, cycle_done;
  logic [3:0] tp;
  logic [3:0] edit_pulse;
  logic [2:0] fail_cnt;

  typedef struct packed {
    logic       csg;
    logic       wsg;
    logic [3:0] edit;
    logic       par_fail;
    logic       restart_req;
    logic       cycle_done;
    logic [3:0] tp;
    logic [2:0] fail_cnt;
    logic       alarm;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  act_ev, exp_ev;
  int   checks = 0;
  int   passes = 0;
  int   model_cnt = 0;
  logic model_alarm = 1'b0;

  sreg_parity_sequencer dut (
    .SIM_CLK     (SIM_CLK),
    .SIM_RST     (SIM_RST),
    .start       (start),
    .chk_en      (chk_en),
    .edit_op     (edit_op),
    .tp_adv      (tp_adv),
    .parity_ok   (parity_ok),
    .gojam       (gojam),
    .alarm_clr   (alarm_clr),
`ifdef SREG_MONPAR_EN
    .monpar      (monpar),
`endif
    .busy        (busy),
    .tp          (tp),
    .csg         (csg),
    .wsg         (wsg),
    .tparg       (tparg),
    .edit_pulse  (edit_pulse),
    .par_fail    (par_fail),
    .fail_cnt    (fail_cnt),
    .alarm       (alarm),
    .restart_req (restart_req),
    .cycle_done  (cycle_done)
  );

  always #5 SIM_CLK = ~SIM_CLK;

  // Any pulse output must match the oldest queued expectation.
  always @(negedge SIM_CLK) begin
    if (!SIM_RST && (csg || wsg || (edit_pulse != 4'd0) || par_fail || restart_req || cycle_done)) begin
      act_ev = '{csg, wsg, edit_pulse, par_fail, restart_req, cycle_done, tp, fail_cnt, alarm};
      checks++;
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL unexpected_event: got %h, expected no event", act_ev);
      end else begin
        exp_ev = exp_q.pop_front();
        if (act_ev === exp_ev) passes++;
        else $display("[TB] FAIL event: got %h, expected %h", act_ev, exp_ev);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic tick();
    @(posedge SIM_CLK);
    #1;
  endtask

  task automatic push_ev(input logic c, input logic w, input logic [3:0] e, input logic pf,
                         input logic rr, input logic cd, input logic [3:0] t);
    exp_q.push_back('{c, w, e, pf, rr, cd, t, 3'(model_cnt), model_alarm});
  endtask

  task automatic applyStimulus(input logic st, input logic ce, input logic [2:0] op, input logic adv,
                               input logic pok, input logic gj, input logic clr, input logic mp);
    start = st; chk_en = ce; edit_op = op; tp_adv = adv;
    parity_ok = pok; gojam = gj; alarm_clr = clr;
`ifdef SREG_MONPAR_EN
    monpar = mp;
`else
    if (mp) $display("[TB] monpar ignored in this build");
`endif
    tick();
    start = 1'b0; chk_en = 1'b0; edit_op = 3'd0; tp_adv = 1'b0;
    parity_ok = 1'b1; gojam = 1'b0; alarm_clr = 1'b0;
`ifdef SREG_MONPAR_EN
    monpar = 1'b0;
`endif
  endtask

  // One memory cycle; the fail counter / alarm model only tracks what the check edge does.
  task automatic run_cycle(input bit chk, input logic [2:0] op, input logic [3:0] exp_edit,
                           input bit pok, input bit mp, input bit clr, input bit skip_start,
                           input bit poke_start, input bit leave_last);
    bit fail, set;
    if (!skip_start) begin
      push_ev(1, 0, 4'd0, 0, 0, 0, 4'd1);
      applyStimulus(1, chk, op, 0, 1, 0, 0, 0);
    end
    for (int t = 1; t < 12; t++) begin
      logic s, pok_d, mp_d, clr_d;
      s = 1'b0; pok_d = 1'b1; mp_d = 1'b0; clr_d = 1'b0;
      if (t == 1) push_ev(0, 1, 4'd0, 0, 0, 0, 4'd2);
      if (t == 6 && poke_start) s = 1'b1;
      if (t == 7) begin
        pok_d = pok; mp_d = mp; clr_d = clr;
        if (chk) begin
          fail = !pok || mp;
          if (fail) begin
            model_cnt = (model_cnt == 7) ? 7 : model_cnt + 1;
            set = (model_cnt >= 2) && !model_alarm;
            if (set) model_alarm = 1'b1;
            else if (clr) model_alarm = 1'b0;
            push_ev(0, 0, 4'd0, 1, set, 0, 4'd8);
          end else begin
            model_cnt = 0;
            if (clr) model_alarm = 1'b0;
          end
        end else if (clr) begin
          model_alarm = 1'b0;
        end
      end
      if (t == 11 && exp_edit != 4'd0) push_ev(0, 0, exp_edit, 0, 0, 0, 4'd12);
      applyStimulus(s, 0, 3'd0, 1, pok_d, 0, clr_d, mp_d);
      if (t == 6) begin
        checkOutput("tparg_in_tp7", 32'(tparg), 32'(chk));
        checkOutput("tp_is_7", 32'(tp), 32'd7);
      end
      if (t == 7) checkOutput("tparg_after_tp7", 32'(tparg), 32'd0);
    end
    if (!leave_last) begin
      push_ev(0, 0, 4'd0, 0, 0, 1, 4'd0);
      applyStimulus(0, 0, 3'd0, 1, 1, 0, 0, 0);
    end
  endtask

  initial begin
    start = 0; chk_en = 0; edit_op = 0; tp_adv = 0; parity_ok = 1; gojam = 0; alarm_clr = 0;
`ifdef SREG_MONPAR_EN
    monpar = 0;
`endif
    SIM_RST = 1'b1;
    tick(); tick();
    SIM_RST = 1'b0;
    checkOutput("reset_outputs",
                32'({busy, tp, csg, wsg, tparg, edit_pulse, par_fail, fail_cnt, alarm, restart_req, cycle_done}),
                32'd0);

    applyStimulus(0, 0, 3'd0, 1, 1, 0, 0, 0);
    checkOutput("idle_tp_adv_ignored", 32'({busy, tp}), 32'd0);

    $display("[TB] nominal cycle, CYR edit");
    run_cycle(1, 3'd1, 4'b0001, 1, 0, 0, 0, 0, 0);
    checkOutput("nominal_idle_after", 32'({busy, tp}), 32'd0);
    checkOutput("nominal_fail_cnt", 32'(fail_cnt), 32'd0);

    $display("[TB] consecutive failures");
    run_cycle(1, 3'd2, 4'b0010, 0, 0, 0, 0, 0, 0);
    checkOutput("fail1_cnt", 32'(fail_cnt), 32'd1);
    checkOutput("fail1_alarm", 32'(alarm), 32'd0);
    run_cycle(1, 3'd3, 4'b0100, 0, 0, 0, 0, 0, 0);
    checkOutput("fail2_cnt", 32'(fail_cnt), 32'd2);
    checkOutput("fail2_alarm", 32'(alarm), 32'd1);
    run_cycle(1, 3'd4, 4'b1000, 0, 0, 0, 0, 0, 0);
    checkOutput("fail3_cnt", 32'(fail_cnt), 32'd3);
    applyStimulus(0, 0, 3'd0, 0, 1, 0, 1, 0);
    model_alarm = 1'b0;
    checkOutput("alarm_cleared", 32'(alarm), 32'd0);

    $display("[TB] fail/pass interleave");
    run_cycle(1, 3'd5, 4'd0, 1, 0, 0, 0, 0, 0);
    checkOutput("pass_resets_cnt", 32'(fail_cnt), 32'd0);
    run_cycle(1, 3'd5, 4'd0, 0, 0, 0, 0, 0, 0);
    checkOutput("interleave_cnt1", 32'(fail_cnt), 32'd1);
    run_cycle(1, 3'd0, 4'd0, 1, 0, 0, 0, 0, 0);
    checkOutput("interleave_cnt0", 32'(fail_cnt), 32'd0);
    run_cycle(1, 3'd0, 4'd0, 0, 0, 0, 0, 0, 0);
    checkOutput("interleave_cnt1b", 32'(fail_cnt), 32'd1);
    checkOutput("interleave_alarm", 32'(alarm), 32'd0);

    $display("[TB] gojam abort");
    push_ev(1, 0, 4'd0, 0, 0, 0, 4'd1);
    applyStimulus(1, 1, 3'd1, 0, 1, 0, 0, 0);
    for (int t = 1; t < 5; t++) begin
      if (t == 1) push_ev(0, 1, 4'd0, 0, 0, 0, 4'd2);
      applyStimulus(0, 0, 3'd0, 1, 1, 0, 0, 0);
    end
    checkOutput("at_tp5", 32'(tp), 32'd5);
    applyStimulus(0, 0, 3'd0, 0, 1, 1, 0, 0);
    checkOutput("gojam_idle", 32'({busy, tp, tparg}), 32'd0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 3'd0, 1, 0, 0, 0, 0);
    checkOutput("gojam_cnt_kept", 32'(fail_cnt), 32'd1);
    applyStimulus(1, 1, 3'd1, 0, 1, 1, 0, 0);
    checkOutput("gojam_beats_start", 32'({busy, tp}), 32'd0);

    $display("[TB] back-to-back start, ignored mid-cycle start, clr vs set");
    run_cycle(0, 3'd0, 4'd0, 1, 0, 0, 0, 0, 1);
    push_ev(1, 0, 4'd0, 0, 0, 1, 4'd1);
    applyStimulus(1, 1, 3'd1, 1, 1, 0, 0, 0);
    checkOutput("b2b_tp1", 32'({busy, tp}), 32'h11);
    run_cycle(1, 3'd1, 4'b0001, 0, 0, 1, 1, 1, 0);
    checkOutput("set_beats_clr", 32'(alarm), 32'd1);
    checkOutput("set_beats_clr_cnt", 32'(fail_cnt), 32'd2);
    run_cycle(0, 3'd0, 4'd0, 0, 0, 0, 0, 0, 0);
    checkOutput("no_check_cnt", 32'(fail_cnt), 32'd2);

`ifdef SREG_MONPAR_EN
    $display("[TB] monitor-forced parity failure");
    applyStimulus(0, 0, 3'd0, 0, 1, 0, 1, 0);
    model_alarm = 1'b0;
    run_cycle(1, 3'd0, 4'd0, 1, 0, 0, 0, 0, 0);
    run_cycle(1, 3'd0, 4'd0, 1, 1, 0, 0, 0, 0);
    checkOutput("monpar_cnt", 32'(fail_cnt), 32'd1);
    checkOutput("monpar_alarm", 32'(alarm), 32'd0);
`endif

    tick(); tick(); tick();
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
